// File: rtl/uart_pkg.sv
// Shared UART package: FSM state encoding, default line constants, bit-timer helper.
// UART_RX_PARITY_EN adds the S_PARITY state.
package uart_pkg;

    localparam int C_CLKFREQ  = 100_000_000;
    localparam int C_BAUDRATE = 10_000_000;
    localparam int C_STOPBIT  = 2;
    localparam int C_DBITS    = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    function automatic int bit_timer_lim(input int clkfreq, input int baudrate);
        return clkfreq / baudrate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line.
// Both flops reset to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop sampling at bit centres, LSB first.
// Define UART_RX_PARITY_EN to expect an even-parity bit and drive parity_err_o.
module uart_rx
    import uart_pkg::*;
#(
    parameter int c_clkfreq  = C_CLKFREQ,
    parameter int c_baudrate = C_BAUDRATE,
    parameter int c_stopbit  = C_STOPBIT,
    parameter int gonbitsys  = C_DBITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [gonbitsys-1:0] dout_o,
    output logic                 rx_done_tick_o,
    output logic                 frame_err_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err_o
`endif
);

    localparam int c_bittimerlim = bit_timer_lim(c_clkfreq, c_baudrate);

    localparam logic [15:0] LIM_END  = 16'(c_bittimerlim - 1);
    localparam logic [15:0] HALF_END = 16'(c_bittimerlim / 2 - 1);
    localparam logic [7:0]  DATA_END = 8'(gonbitsys - 1);
    localparam logic [7:0]  STOP_END = 8'(c_stopbit - 1);

    logic rx_s;
    logic rx_prev;

    state_t                 state, state_n;
    logic [15:0]            timer, timer_n;
    logic [7:0]             bit_cnt, cnt_n;
    logic [gonbitsys-1:0]   shreg, shreg_n;
    logic                   stop_err, stop_err_n;
    logic [gonbitsys-1:0]   dout_n;
    logic                   tick_n;
    logic                   ferr_n;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad, par_bad_n;
    logic                   perr_n;
`endif

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            timer          <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            stop_err       <= 1'b0;
            rx_prev        <= 1'b1;
            dout_o         <= '0;
            rx_done_tick_o <= 1'b0;
            frame_err_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad        <= 1'b0;
            parity_err_o   <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            timer          <= timer_n;
            bit_cnt        <= cnt_n;
            shreg          <= shreg_n;
            stop_err       <= stop_err_n;
            rx_prev        <= rx_s;
            dout_o         <= dout_n;
            rx_done_tick_o <= tick_n;
            frame_err_o    <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad        <= par_bad_n;
            parity_err_o   <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        cnt_n      = bit_cnt;
        shreg_n    = shreg;
        stop_err_n = stop_err;
        dout_n     = dout_o;
        tick_n     = 1'b0;
        ferr_n     = frame_err_o;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
        perr_n     = parity_err_o;
`endif
        unique case (state)
            S_IDLE: begin
                // only a real 1->0 transition starts a frame
                if (rx_prev && !rx_s) begin
                    state_n = S_START;
                    timer_n = '0;
                end
            end
            S_START: begin
                if (timer == HALF_END) begin
                    timer_n    = '0;
                    cnt_n      = '0;
                    stop_err_n = 1'b0;
                    state_n    = rx_s ? S_IDLE : S_DATA;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            S_DATA: begin
                if (timer == LIM_END) begin
                    timer_n = '0;
                    shreg_n = {rx_s, shreg[gonbitsys-1:1]};
                    if (bit_cnt == DATA_END) begin
                        cnt_n   = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        cnt_n = bit_cnt + 8'd1;
                    end
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (timer == LIM_END) begin
                    timer_n   = '0;
                    par_bad_n = (^shreg) ^ rx_s;
                    state_n   = S_STOP;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (timer == LIM_END) begin
                    timer_n    = '0;
                    stop_err_n = stop_err | ~rx_s;
                    if (bit_cnt == STOP_END) begin
                        dout_n  = shreg;
                        ferr_n  = stop_err | ~rx_s;
                        tick_n  = 1'b1;
                        cnt_n   = '0;
                        state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_n  = par_bad;
`endif
                    end else begin
                        cnt_n = bit_cnt + 8'd1;
                    end
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: Parameter c_clkfreq, default 100_000_000: system clock frequency in Hz.
- REQ-002: Parameter c_baudrate, default 10_000_000: line bit rate in baud.
- REQ-003: Parameter c_stopbit, default 2: number of stop bits per frame (1 or 2).
- REQ-004: Parameter gonbitsys, default 10: data bits per frame.
- REQ-005: Port clk, input, 1 bit: system clock; all logic on the rising edge.
- REQ-006: Port rst, input, 1 bit: asynchronous active-high reset.
- REQ-007: Port rx_i, input, 1 bit: serial line; idle high; asynchronous to clk.
- REQ-008: Port dout_o, output, gonbitsys bits: last received data word.
- REQ-009: Port rx_done_tick_o, output, 1 bit: one-clk pulse when a frame completes.
- REQ-010: Port frame_err_o, output, 1 bit: high when any stop-bit sample of the last frame was 0.

Function
- REQ-011: rx_i SHALL pass through a 2-flop synchronizer before any use.
- REQ-012: Bit period SHALL be c_bittimerlim = c_clkfreq/c_baudrate clocks (10 at defaults), using integer division.
- REQ-013: The FSM SHALL have the states S_IDLE, S_START, S_DATA and S_STOP.
- REQ-014: In S_IDLE, a synchronized falling edge (1 to 0) SHALL move the FSM to S_START and clear the bit timer.
- REQ-015: In S_START, after c_bittimerlim/2 clocks, a sampled 0 SHALL move the FSM to S_DATA; a sampled 1 (glitch) SHALL return it to S_IDLE without a tick.
- REQ-016: In S_DATA, each bit SHALL be sampled every c_bittimerlim clocks, at bit centre.
- REQ-017: Data SHALL be received LSB first into a shift register, right-shifting in from the MSB.
- REQ-018: After gonbitsys samples, the FSM SHALL go to S_STOP.
- REQ-019: In S_STOP, c_stopbit samples SHALL be taken at bit centres, and any 0 SHALL be latched as a framing error.
- REQ-020: At the final stop-bit sample, the shift register SHALL be copied to dout_o and frame_err_o SHALL be updated in the same cycle.
- REQ-021: rx_done_tick_o SHALL pulse high for exactly 1 clk in that same cycle, and the FSM SHALL go to S_IDLE.
- REQ-022: dout_o and frame_err_o SHALL hold their values until the next completed frame.
- REQ-023: A falling edge during S_DATA or S_STOP SHALL be ignored; only S_IDLE detects a start.
- REQ-024: After S_STOP, a line that is already low SHALL NOT start a frame until a 1 to 0 transition is seen.
- REQ-025: Latency SHALL be from the line's start edge to rx_done_tick_o = 2 (sync) + c_bittimerlim/2 + (gonbitsys + c_stopbit)·c_bittimerlim clocks, ±1.

Reset
- REQ-026: rst high SHALL asynchronously force the FSM to S_IDLE and clear the bit timer, bit counter and shift register.
- REQ-027: rst high SHALL asynchronously set dout_o = 0, rx_done_tick_o = 0, frame_err_o = 0, and both synchronizer flops to 1.
- REQ-028: A reset during a frame SHALL abort it with no tick; reception SHALL resume on the next falling edge after rst deasserts.

Configuration
- REQ-029: Macro UART_RX_PARITY_EN defined: an even-parity bit SHALL be expected after the data bits, in a state S_PARITY.
- REQ-030: With UART_RX_PARITY_EN defined, an output parity_err_o SHALL update with the tick and reset to 0.
- REQ-031: Macro UART_RX_PARITY_EN undefined: there SHALL be no S_PARITY state and no parity_err_o port, and the frame SHALL be start + data + stop only.

Structure
- REQ-032: A shared package uart_pkg SHALL hold the FSM state encoding, the default clock, baud, stop-bit and width constants, and a function computing c_bittimerlim.
- REQ-033: The package SHALL be shared with uart_tx.
- REQ-034: The bench SHALL include a sub-module uart_rx_sync (2-flop synchronizer, reset value 1); all other logic SHALL be in a single always block pair (sequential and next-state).

Verification
- REQ-035: uart_tx sends 10'b1100110011 looped back to rx_i -> one rx_done_tick_o about 130 clk later, dout_o = 10'b1100110011, frame_err_o = 0.
- REQ-036: Back-to-back frames 10'b1100110011 then 10'b1110001110 -> two ticks, with dout_o matching each frame in order.
- REQ-037: A 3-clk low glitch on idle rx_i -> no tick; dout_o unchanged; FSM back in S_IDLE.
- REQ-038: Frame 10'b1010101010 with the second stop bit forced to 0 -> tick with dout_o = 10'b1010101010 and frame_err_o = 1.
- REQ-039: rst pulsed at the 5th data bit -> no tick and all outputs 0; the next full frame 10'b0000011111 is received correctly.
- REQ-040: With UART_RX_PARITY_EN, frame 10'b1100110011 with odd parity injected -> tick with parity_err_o = 1.
